// File: rtl/phase_step_sequencer.sv
// phase_step_sequencer: splits a total phase offset into bounded steps and drives
// one adjust-enable pulse per step toward the DDSM phase adder.
// The phase-add word is stable one cycle before the enable rises.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_total, i_max_step   request handshake
//   i_abort               stop at the next step boundary
//   o_phaseadjusten, o_phaseadd                         phase adder interface
//   o_busy, o_done, o_aborted, o_step_count             host status
module phase_step_sequencer #(
    parameter int unsigned P_DATA_WIDTH = 12,
    parameter int unsigned P_REQ_WIDTH  = 16,
    parameter int unsigned P_PULSE_LEN  = 4,
    parameter int unsigned P_GAP_LEN    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [P_REQ_WIDTH-1:0]  i_req_total,
    input  logic [P_DATA_WIDTH-1:0] i_max_step,
    input  logic                    i_abort,
    output logic                    o_phaseadjusten,
    output logic [P_DATA_WIDTH-1:0] o_phaseadd,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_aborted,
    output logic [P_REQ_WIDTH-1:0]  o_step_count
);

    localparam int unsigned DW      = P_DATA_WIDTH;
    localparam int unsigned RW      = P_REQ_WIDTH;
    localparam int unsigned TMR_MAX = (P_PULSE_LEN > P_GAP_LEN) ? P_PULSE_LEN : P_GAP_LEN;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(P_PULSE_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(P_GAP_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   max_q, max_d;
    logic [DW-1:0]   step_q, step_d;
    logic            abort_q, abort_d;
    logic [RW-1:0]   cnt_q, cnt_d;

    logic            ready_q, ready_d;
    logic            en_q, en_d;
    logic [DW-1:0]   pa_q, pa_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;

    logic            accept;
    logic            abort_now;
    logic [DW-1:0]   max_in_eff;

    // Step size is the smaller of what is left and the per-step limit.
    function automatic logic [DW-1:0] min_step(input logic [RW-1:0] rem,
                                               input logic [DW-1:0] mx);
        if (rem < RW'(mx)) begin
            return DW'(rem);
        end
        return mx;
    endfunction

    // ready_q is only high in IDLE, so it doubles as the acceptance qualifier.
    assign accept     = i_req_valid & ready_q;
    assign abort_now  = abort_q | i_abort;
    assign max_in_eff = (i_max_step == '0) ? '1 : i_max_step;

    // Next-state, counters, and next value of every registered output.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        max_d   = max_q;
        step_d  = step_q;
        abort_d = abort_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (accept) begin
                    rem_d   = i_req_total;
                    max_d   = max_in_eff;
                    cnt_d   = '0;
                    // Abort with the handshake takes effect at the first SETUP.
                    abort_d = i_abort;
                    if (i_req_total == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        step_d  = min_step(i_req_total, max_in_eff);
                    end
                end
            end
            ST_SETUP: begin
                abort_d = abort_now;
                tmr_d   = '0;
                state_d = abort_now ? ST_DONE : ST_PULSE;
            end
            ST_PULSE: begin
                // A started pulse always runs to completion.
                abort_d = abort_now;
                if (tmr_q == PULSE_LAST) begin
                    rem_d   = rem_q - RW'(step_q);
                    cnt_d   = cnt_q + RW'(1);
                    tmr_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_GAP: begin
                abort_d = abort_now;
                if (tmr_q == GAP_LAST) begin
                    tmr_d = '0;
                    if ((rem_q == '0) || abort_now) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        step_d  = min_step(rem_q, max_q);
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are a registered function of the state being entered.
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        en_d      = (state_d == ST_PULSE);
        pa_d      = ((state_d == ST_SETUP) || (state_d == ST_PULSE)) ? step_d : '0;
        done_d    = (state_d == ST_DONE);
        aborted_d = (state_d == ST_DONE) & abort_d;
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            rem_q     <= '0;
            max_q     <= '0;
            step_q    <= '0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            en_q      <= 1'b0;
            pa_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            rem_q     <= rem_d;
            max_q     <= max_d;
            step_q    <= step_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            en_q      <= en_d;
            pa_q      <= pa_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_req_ready     = ready_q;
    assign o_phaseadjusten = en_q;
    assign o_phaseadd      = pa_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_aborted       = aborted_q;
    assign o_step_count    = cnt_q;

endmodule

// File: tb/tb_phase_step_sequencer.sv
// Bench for phase_step_sequencer: expected step words are queued when a request
// is issued and popped at every enable rising edge; each scenario task checks
// completion status inline.
module tb_phase_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_total;
    logic [11:0] max_step;
    logic        abort_in;
    logic        en;
    logic [11:0] pa;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] step_count;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];
    logic        prev_en = 1'b0;
    logic [11:0] prev_pa = '0;
    int          pulse_len = 0;

    always #5 clk = ~clk;

    phase_step_sequencer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_total     (req_total),
        .i_max_step      (max_step),
        .i_abort         (abort_in),
        .o_phaseadjusten (en),
        .o_phaseadd      (pa),
        .o_busy          (busy),
        .o_done          (done),
        .o_aborted       (aborted),
        .o_step_count    (step_count)
    );

    // Advance to the next falling edge and score pulses against the queue.
    task automatic tick();
        logic [11:0] exp;
        @(negedge clk);
        if (rst) begin
            prev_en   = 1'b0;
            prev_pa   = '0;
            pulse_len = 0;
        end else begin
            if (en && !prev_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: phaseadd=%0h, required no pulse", pa);
                end else begin
                    exp = exp_q.pop_front();
                    if (pa !== exp || prev_pa !== exp) begin
                        errors++;
                        $display("FAIL step_word: at_rise=%0h before_rise=%0h, required %0h", pa, prev_pa, exp);
                    end
                end
            end
            if (en) pulse_len++;
            if (!en && prev_en) begin
                checks++;
                if (pulse_len != 4 || pa !== 12'h0) begin
                    errors++;
                    $display("FAIL pulse_shape: len=%0d gap_phaseadd=%0h, required len=4 phaseadd=0", pulse_len, pa);
                end
                pulse_len = 0;
            end
            prev_en = en;
            prev_pa = pa;
        end
    endtask

    // Reference splitting of a request into step words.
    task automatic push_steps(input logic [15:0] total, input logic [11:0] mx);
        int rem;
        int eff;
        int s;
        rem = int'(total);
        eff = (mx == 12'h0) ? 4095 : int'(mx);
        while (rem > 0) begin
            s = (rem < eff) ? rem : eff;
            exp_q.push_back(12'(s));
            rem -= s;
        end
    endtask

    // Present a request for one clock; returns on the falling edge after acceptance.
    task automatic send_req(input logic [15:0] total, input logic [11:0] mx, input logic abrt);
        req_valid = 1'b1;
        req_total = total;
        max_step  = mx;
        abort_in  = abrt;
        tick();
        req_valid = 1'b0;
        abort_in  = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
        end
        to = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_total = '0;
        max_step  = '0;
        abort_in  = 1'b0;
        repeat (3) tick();
        checks++;
        if ({en, pa, busy, done, aborted, step_count, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b pa=%0h busy=%b done=%b ab=%b cnt=%0d rdy=%b, required all 0",
                     en, pa, busy, done, aborted, step_count, req_ready);
        end
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_first_cycle: %b, required 0", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_second_cycle: rdy=%b busy=%b, required rdy=1 busy=0", req_ready, busy);
        end
    endtask

    // Request that divides evenly: 4 steps of 0x400, done 52 cycles after acceptance.
    task automatic test_even_split();
        int cyc;
        bit to;
        push_steps(16'h1000, 12'h400);
        send_req(16'h1000, 12'h400, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 52 || step_count !== 16'd4 || aborted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL even_split: to=%b cyc=%0d cnt=%0d ab=%b busy=%b, required cyc=52 cnt=4 ab=0 busy=1",
                     to, cyc, step_count, aborted, busy);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0 || step_count !== 16'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL even_split_idle: rdy=%b done=%b cnt=%0d left=%0d, required rdy=1 done=0 cnt=4 left=0",
                     req_ready, done, step_count, exp_q.size());
        end
    endtask

    // Residue step: 400, 400, 200.
    task automatic test_residue();
        int cyc;
        bit to;
        push_steps(16'd1000, 12'd400);
        send_req(16'd1000, 12'd400, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 39 || step_count !== 16'd3 || aborted !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL residue: to=%b cyc=%0d cnt=%0d ab=%b left=%0d, required cyc=39 cnt=3 ab=0 left=0",
                     to, cyc, step_count, aborted, exp_q.size());
        end
        tick();
    endtask

    // Max of zero means all-ones: 4095 then 905.
    task automatic test_max_zero();
        int cyc;
        bit to;
        push_steps(16'd5000, 12'h000);
        send_req(16'd5000, 12'h000, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 26 || step_count !== 16'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL max_zero: to=%b cyc=%0d cnt=%0d left=%0d, required cyc=26 cnt=2 left=0",
                     to, cyc, step_count, exp_q.size());
        end
        tick();
    endtask

    task automatic test_zero_total();
        int cyc;
        bit to;
        send_req(16'd0, 12'h100, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 0 || step_count !== 16'd0 || aborted !== 1'b0 || en !== 1'b0) begin
            errors++;
            $display("FAIL zero_total: to=%b cyc=%0d cnt=%0d ab=%b en=%b, required cyc=0 cnt=0 ab=0 en=0",
                     to, cyc, step_count, aborted, en);
        end
        tick();
    endtask

    // Abort during the 2nd pulse: that step and its gap finish, no 3rd step.
    task automatic test_abort_mid_pulse();
        int cyc;
        bit to;
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h100);
        send_req(16'h1000, 12'h100, 1'b0);
        repeat (15) tick();
        checks++;
        if (en !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: en=%b, required 1 during 2nd pulse", en);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        wait_done(cyc, to);
        checks++;
        if (to || aborted !== 1'b1 || step_count !== 16'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_mid_pulse: to=%b ab=%b cnt=%0d left=%0d, required ab=1 cnt=2 left=0",
                     to, aborted, step_count, exp_q.size());
        end
        repeat (20) tick();
        checks++;
        if (aborted !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: ab=%b rdy=%b, required ab=0 rdy=1", aborted, req_ready);
        end
    endtask

    // Abort together with the handshake: done at the first SETUP, no pulse.
    task automatic test_abort_on_accept();
        int cyc;
        bit to;
        send_req(16'h0100, 12'h010, 1'b1);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 1 || aborted !== 1'b1 || step_count !== 16'd0 || pa !== 12'h0) begin
            errors++;
            $display("FAIL abort_on_accept: to=%b cyc=%0d ab=%b cnt=%0d pa=%0h, required cyc=1 ab=1 cnt=0 pa=0",
                     to, cyc, aborted, step_count, pa);
        end
        tick();
    endtask

    // Reset mid-pulse, then a fresh request completes normally.
    task automatic test_reset_mid_pulse();
        int cyc;
        bit to;
        exp_q.push_back(12'h400);
        send_req(16'h1000, 12'h400, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (en !== 1'b0 || pa !== 12'h0 || busy !== 1'b0 || step_count !== 16'd0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse: en=%b pa=%0h busy=%b cnt=%0d rdy=%b, required all 0",
                     en, pa, busy, step_count, req_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover: left=%0d rdy=%b, required left=0 rdy=1", exp_q.size(), req_ready);
        end
        exp_q.delete();
        push_steps(16'h0020, 12'h010);
        send_req(16'h0020, 12'h010, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 26 || step_count !== 16'd2 || aborted !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_req: to=%b cyc=%0d cnt=%0d ab=%b left=%0d, required cyc=26 cnt=2 ab=0 left=0",
                     to, cyc, step_count, aborted, exp_q.size());
        end
        tick();
    endtask

    // Second request issued on the first ready cycle after done.
    task automatic test_back_to_back();
        int cyc;
        bit to;
        push_steps(16'h0030, 12'h010);
        send_req(16'h0030, 12'h010, 1'b0);
        wait_done(cyc, to);
        tick();
        push_steps(16'd5, 12'd3);
        send_req(16'd5, 12'd3, 1'b0);
        checks++;
        if (step_count !== 16'd0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: cnt=%0d rdy=%b busy=%b, required cnt=0 rdy=0 busy=1",
                     step_count, req_ready, busy);
        end
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 26 || step_count !== 16'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_second: to=%b cyc=%0d cnt=%0d left=%0d, required cyc=26 cnt=2 left=0",
                     to, cyc, step_count, exp_q.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_even_split();
        test_residue();
        test_max_zero();
        test_zero_total();
        test_abort_mid_pulse();
        test_abort_on_accept();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
